// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with configurable wait states for the multi-cycle MIPS core
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        memwr,
    input  logic        lb1,
    input  logic        sb1,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
    state_t                state;
    logic [2:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           wd, rd_hold, word;
    logic [7:0]            bsel;
    logic                  wr, lb, sb, err_hold, mis;
    logic [31:0]           mem [2**DEPTH_LOG2] = '{default: '0};
    assign word = mem[idx];
    assign bsel = word[{lane, 3'b000} +: 8];
    assign mis  = (wr ? !sb : !lb) && lane != 2'd0;
    // control FSM: latch request, count wait states, resolve the access, then present it with ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            lane     <= '0;
            wd       <= '0;
            wr       <= 1'b0;
            lb       <= 1'b0;
            sb       <= 1'b0;
            rd_hold  <= '0;
            err_hold <= 1'b0;
            rdata    <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    idx   <= addr[DEPTH_LOG2+1:2];
                    lane  <= addr[1:0];
                    wd    <= wdata;
                    wr    <= memwr;
                    lb    <= lb1;
                    sb    <= sb1;
                    cnt   <= 3'(WAIT_CYCLES);
                    busy  <= 1'b1;
                    state <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
                WAIT: begin
                    cnt   <= cnt - 3'd1;
                    state <= (cnt == 3'd1) ? RESP : WAIT;
                end
                RESP: begin
                    rd_hold  <= (wr || mis) ? rdata : (lb ? {{24{bsel[7]}}, bsel} : word);
                    err_hold <= mis;
                    state    <= DONE;
                end
                DONE: begin
                    rdata <= rd_hold;
                    err   <= err_hold;
                    ack   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // store commit happens only on the RESP edge; reset forces IDLE so an aborted store never lands
    always_ff @(posedge clk) begin
        if (state == RESP && wr && !mis) begin
            if (sb)
                mem[idx][{lane, 3'b000} +: 8] <= wd[7:0];
            else
                mem[idx] <= wd;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with wait-state and zero-wait instances
module tb_dmem_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req = 1'b0, memwr = 1'b0, lb1 = 1'b0, sb1 = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        ack, busy, err;
    logic        req0 = 1'b0, memwr0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
    logic        ack0, busy0, err0;
    typedef struct {logic [31:0] rd; logic er;} exp_t;
    exp_t sbq[$];
    exp_t e;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .memwr(memwr), .lb1(lb1), .sb1(sb1),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
    );
    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .memwr(memwr0), .lb1(1'b0), .sb1(1'b0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every ack of the wait-state instance is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && ack) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack");
            end else begin
                e = sbq.pop_front();
                check("rdata", rdata, e.rd);
                check("err", {31'b0, err}, {31'b0, e.er});
            end
        end
    end

    task automatic op(input logic w, input logic l, input logic s, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] erd, input logic eer);
        int n;
        sbq.push_back('{erd, eer});
        @(negedge clk);
        memwr = w; lb1 = l; sb1 = s; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        n = 0;
        while (!ack && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("ack_latency", 32'(n), 32'd4);
        check("busy_with_ack", {31'b0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic op0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] erd);
        int n;
        @(negedge clk);
        memwr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        @(posedge clk);
        #1 req0 = 1'b0;
        n = 0;
        while (!ack0 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("ack_latency_w0", 32'(n), 32'd2);
        check("rdata_w0", rdata0, erd);
        check("err_w0", {31'b0, err0}, 32'd0);
    endtask

    task automatic idle_acks(input int cycles, input string name);
        int n;
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack) n++;
        end
        check(name, 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #2;
        check("reset_rdata", rdata, 32'd0);
        check("reset_flags", {29'b0, ack, busy, err}, 32'd0);
        @(negedge clk) rst = 1'b0;
        idle_acks(10, "idle_no_ack");
        op(1, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        op(0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        op(0, 0, 0, 32'h1010, 32'h0, 32'hDEADBEEF, 0);
        op(1, 0, 0, 32'h20, 32'h11223344, 32'hDEADBEEF, 0);
        op(1, 0, 1, 32'h21, 32'h00000080, 32'hDEADBEEF, 0);
        op(0, 0, 0, 32'h20, 32'h0, 32'h11228044, 0);
        op(0, 1, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0);
        op(0, 1, 0, 32'h23, 32'h0, 32'h00000011, 0);
        op(1, 0, 0, 32'h30, 32'h55667788, 32'h00000011, 0);
        op(1, 0, 0, 32'h32, 32'h12345678, 32'h00000011, 1);
        op(0, 0, 0, 32'h30, 32'h0, 32'h55667788, 0);
        op(0, 0, 0, 32'h02, 32'h0, 32'h55667788, 1);
        op(0, 1, 0, 32'h22, 32'h0, 32'h00000022, 0);
        op(1, 1, 0, 32'h34, 32'hA5A5A5A5, 32'h00000022, 0);
        op(0, 0, 1, 32'h34, 32'h0, 32'hA5A5A5A5, 0);
        // second req one cycle after acceptance must be dropped
        sbq.push_back('{32'hDEADBEEF, 1'b0});
        @(negedge clk);
        memwr = 0; lb1 = 0; sb1 = 0; addr = 32'h10; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        addr = 32'h20; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack) n++;
        end
        check("busy_single_ack", 32'(n), 32'd1);
        op(1, 0, 0, 32'h40, 32'h01020304, 32'hDEADBEEF, 0);
        // reset while the store sits in WAIT
        @(negedge clk);
        memwr = 1; addr = 32'h40; wdata = 32'hCAFEF00D; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_rdata", rdata, 32'd0);
        check("async_reset_flags", {29'b0, ack, busy, err}, 32'd0);
        @(negedge clk) rst = 1'b0;
        idle_acks(8, "aborted_no_ack");
        op(0, 0, 0, 32'h40, 32'h0, 32'h01020304, 0);
        op0(1, 32'h4, 32'h00000077, 32'h0);
        op0(0, 32'h4, 32'h0, 32'h00000077);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
